// File: rtl/lane_input_encoder.sv
// lane_input_encoder
//   Turns raw board buttons/switches into a stream of 8-bit state frames for
//   the UART transmitter. Every raw input is synchronised (2 FF) and debounced.
//   Up/down rising edges move a saturating lane counter. Fire presses are
//   rate-limited by a cooldown and are never lost. Each change produces one
//   frame {boot, 0, fire, proj, lane[3:0]} on a valid/ready handshake. The frame
//   is held stable under backpressure, and events that arrive while it waits
//   coalesce into the next frame.
//
//   Optional feature: define LANE_INPUT_AUTO_REPEAT_EN to enable held-button
//   auto-repeat (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   button_up    raw up button (asynchronous)
//   button_down  raw down button (asynchronous)
//   is_firing    raw fire button (asynchronous)
//   projectile   raw projectile-type switch level (asynchronous)
//   tx_data      frame to UART
//   tx_valid     frame available
//   tx_ready     UART accepts frame
//   lane         current lane (1..NUM_LANES)
module lane_input_encoder #(
  parameter int NUM_LANES        = 9,
  parameter int START_LANE       = 5,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int FIRE_COOLDOWN    = 1000000,
  parameter int HEARTBEAT_CYCLES = 0,
  parameter int REPEAT_DELAY     = 25000000,
  parameter int REPEAT_PERIOD    = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_up,
  input  logic       button_down,
  input  logic       is_firing,
  input  logic       projectile,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] lane
);

  if (NUM_LANES < 2 || NUM_LANES > 15 || START_LANE < 1 || START_LANE > NUM_LANES ||
      DEBOUNCE_CYCLES < 1 || FIRE_COOLDOWN < 0 || HEARTBEAT_CYCLES < 0 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("lane_input_encoder: illegal parameter set");
  end

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CDW     = $clog2(FIRE_COOLDOWN + 2);
  localparam int HBW     = $clog2(HEARTBEAT_CYCLES + 2);
  localparam int HB_LAST = (HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0;
  localparam logic [3:0] LANE_START = 4'(START_LANE);
  localparam logic [3:0] LANE_MAX   = 4'(NUM_LANES);

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_SEND} state_t;

  // Bit order: 0 up, 1 down, 2 fire, 3 projectile
  logic [3:0]     raw, sync1, sync2, lvl, lvl_q;
  logic [DBW-1:0] db_cnt [4];

  assign raw = {projectile, is_firing, button_down, button_up};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int unsigned i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  logic up_rise, dn_rise, fire_rise, proj_chg;
  assign up_rise   = lvl[0] & ~lvl_q[0];
  assign dn_rise   = lvl[1] & ~lvl_q[1];
  assign fire_rise = lvl[2] & ~lvl_q[2];
  assign proj_chg  = lvl[3] ^ lvl_q[3];

  logic rep_up, rep_dn;

`ifdef LANE_INPUT_AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPW    = $clog2(RP_MAX + 1);

  logic [RPW-1:0] rpt_cnt, rpt_target;
  logic           rpt_phase, rpt_hold, rpt_step;

  // Exactly one direction held; pressing both or releasing stops repeat.
  assign rpt_hold   = lvl[0] ^ lvl[1];
  assign rpt_target = rpt_phase ? RPW'(REPEAT_PERIOD - 1) : RPW'(REPEAT_DELAY - 1);
  assign rpt_step   = rpt_hold && (rpt_cnt == rpt_target);
  assign rep_up     = rpt_step & lvl[0];
  assign rep_dn     = rpt_step & lvl[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (!rpt_hold) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b0;
    end else if (rpt_step) begin
      rpt_cnt   <= '0;
      rpt_phase <= 1'b1;
    end else begin
      rpt_cnt   <= rpt_cnt + 1'b1;
    end
  end
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  logic           step_up, step_dn, move_up, move_dn, fire_acc, hb_fire;
  logic           dirty, fire_pend;
  logic [CDW-1:0] cd_cnt;
  logic [HBW-1:0] hb_cnt;
  state_t         state, state_n;
  logic           load_boot, capture, release_frame;

  assign step_up  = up_rise | rep_up;
  assign step_dn  = dn_rise | rep_dn;
  assign move_up  = step_up & ~step_dn & (lane < LANE_MAX);
  assign move_dn  = step_dn & ~step_up & (lane > 4'd1);
  assign fire_acc = fire_rise & (cd_cnt == '0);
  assign hb_fire  = (HEARTBEAT_CYCLES != 0) && (state == S_IDLE) && !dirty &&
                    (hb_cnt == HBW'(HB_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_BOOT;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    load_boot     = 1'b0;
    capture       = 1'b0;
    release_frame = 1'b0;
    case (state)
      S_BOOT: begin
        load_boot = 1'b1;
        state_n   = S_SEND;
      end
      S_IDLE: begin
        if (dirty) begin
          capture = 1'b1;
          state_n = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready) begin
          release_frame = 1'b1;
          state_n       = S_IDLE;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane      <= LANE_START;
      dirty     <= 1'b0;
      fire_pend <= 1'b0;
      cd_cnt    <= '0;
      hb_cnt    <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
    end else begin
      if (move_up)      lane <= lane + 4'd1;
      else if (move_dn) lane <= lane - 4'd1;

      // New events win over the capture clear so nothing arriving in the
      // capture cycle is lost; it simply produces the next frame.
      dirty     <= (dirty & ~capture) | move_up | move_dn | proj_chg | fire_acc | hb_fire;
      fire_pend <= (fire_pend & ~capture) | fire_acc;

      if (fire_acc)          cd_cnt <= CDW'(FIRE_COOLDOWN);
      else if (cd_cnt != '0) cd_cnt <= cd_cnt - 1'b1;

      if (load_boot || capture || hb_fire)
        hb_cnt <= '0;
      else if ((HEARTBEAT_CYCLES != 0) && (state == S_IDLE) && !dirty)
        hb_cnt <= hb_cnt + 1'b1;

      if (load_boot) begin
        tx_data  <= {1'b1, 1'b0, 1'b0, lvl[3], LANE_START};
        tx_valid <= 1'b1;
      end else if (capture) begin
        tx_data  <= {1'b0, 1'b0, fire_pend, lvl[3], lane};
        tx_valid <= 1'b1;
      end else if (release_frame) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lane_input_encoder.sv
module tb_lane_input_encoder;

  logic       clk;
  logic       rst;
  logic       button_up, button_down, is_firing, projectile;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] lane;

  logic       hb_proj;
  logic [7:0] hb_tx_data;
  logic       hb_tx_valid;
  logic [3:0] hb_lane;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] q[$];
  logic [7:0] hb_q[$];
  int         hb_t[$];

  lane_input_encoder #(
    .NUM_LANES(9), .START_LANE(5), .DEBOUNCE_CYCLES(4),
    .FIRE_COOLDOWN(20), .HEARTBEAT_CYCLES(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .button_up(button_up), .button_down(button_down),
    .is_firing(is_firing), .projectile(projectile),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .lane(lane)
  );

  lane_input_encoder #(
    .NUM_LANES(9), .START_LANE(5), .DEBOUNCE_CYCLES(4),
    .FIRE_COOLDOWN(20), .HEARTBEAT_CYCLES(50)
  ) u_hb (
    .clk(clk), .rst(rst),
    .button_up(1'b0), .button_down(1'b0),
    .is_firing(1'b0), .projectile(hb_proj),
    .tx_data(hb_tx_data), .tx_valid(hb_tx_valid), .tx_ready(1'b1),
    .lane(hb_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) q.push_back(tx_data);
    if (!rst && hb_tx_valid) begin
      hb_q.push_back(hb_tx_data);
      hb_t.push_back(cyc);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic press_up();
    button_up = 1'b1; tick(10);
    button_up = 1'b0; tick(10);
  endtask

  task automatic press_down();
    button_down = 1'b1; tick(10);
    button_down = 1'b0; tick(10);
  endtask

  task automatic press_fire();
    is_firing = 1'b1; tick(10);
    is_firing = 1'b0; tick(10);
  endtask

  initial begin
    rst = 1'b1; button_up = 1'b0; button_down = 1'b0; is_firing = 1'b0;
    projectile = 1'b0; tx_ready = 1'b1; hb_proj = 1'b0;
    tick(3);
    chk("reset_valid", 32'(tx_valid), 32'h0);
    chk("reset_data", 32'(tx_data), 32'h00);
    chk("reset_lane", 32'(lane), 32'd5);

    // Boot frame, then silence
    rst = 1'b0;
    tick(110);
    chk("boot_count", 32'(q.size()), 32'd1);
    chk("boot_frame", 32'(q[0]), 32'h85);
    q.delete();

    // Five up presses, saturating at lane 9
    repeat (5) press_up();
    chk("up_count", 32'(q.size()), 32'd4);
    chk("up_f0", 32'(q[0]), 32'h06);
    chk("up_f1", 32'(q[1]), 32'h07);
    chk("up_f2", 32'(q[2]), 32'h08);
    chk("up_f3", 32'(q[3]), 32'h09);
    chk("up_lane_sat", 32'(lane), 32'd9);
    q.delete();

    // Short glitch on down, then up+down together
    button_down = 1'b1; tick(2);
    button_down = 1'b0; tick(20);
    button_up = 1'b1; button_down = 1'b1; tick(10);
    button_up = 1'b0; button_down = 1'b0; tick(10);
    chk("glitch_both_count", 32'(q.size()), 32'd0);
    chk("glitch_both_lane", 32'(lane), 32'd9);

    // Back down to lane 5
    repeat (4) press_down();
    chk("down_count", 32'(q.size()), 32'd4);
    chk("down_f0", 32'(q[0]), 32'h08);
    chk("down_f1", 32'(q[1]), 32'h07);
    chk("down_f2", 32'(q[2]), 32'h06);
    chk("down_f3", 32'(q[3]), 32'h05);
    chk("down_lane", 32'(lane), 32'd5);
    q.delete();

    // Backpressure: fire frame held while an up press arrives
    tx_ready = 1'b0;
    is_firing = 1'b1; tick(10);
    is_firing = 1'b0; tick(5);
    button_up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("stall_hold_a", {23'd0, tx_valid, tx_data}, 32'h125);
      tick(1);
    end
    button_up = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("stall_hold_b", {23'd0, tx_valid, tx_data}, 32'h125);
      tick(1);
    end
    chk("stall_lane", 32'(lane), 32'd6);
    tx_ready = 1'b1;
    tick(5);
    chk("stall_count", 32'(q.size()), 32'd2);
    chk("stall_f0", 32'(q[0]), 32'h25);
    chk("stall_f1", 32'(q[1]), 32'h06);
    q.delete();

    // Second fire press inside the 20-cycle cooldown is ignored
    is_firing = 1'b1; tick(8);
    is_firing = 1'b0; tick(7);
    is_firing = 1'b1; tick(8);
    is_firing = 1'b0; tick(30);
    chk("cooldown_count", 32'(q.size()), 32'd1);
    chk("cooldown_f0", 32'(q[0]), 32'h26);
    q.delete();
    press_fire();
    chk("refire_count", 32'(q.size()), 32'd1);
    chk("refire_f0", 32'(q[0]), 32'h26);
    q.delete();

    // Projectile toggle at lane 5
    press_down();
    projectile = 1'b1; tick(10);
    projectile = 1'b0; tick(15);
    chk("proj_count", 32'(q.size()), 32'd3);
    chk("proj_f0", 32'(q[0]), 32'h05);
    chk("proj_f1", 32'(q[1]), 32'h15);
    chk("proj_f2", 32'(q[2]), 32'h05);
    q.delete();

    // Reset while a frame is stalled
    tx_ready = 1'b0;
    press_up();
    chk("pre_rst_valid", {23'd0, tx_valid, tx_data}, 32'h106);
    chk("pre_rst_lane", 32'(lane), 32'd6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(tx_valid), 32'h0);
    chk("async_rst_lane", 32'(lane), 32'd5);
    tick(3);
    tx_ready = 1'b1;
    rst = 1'b0;
    tick(20);
    chk("reboot_count", 32'(q.size()), 32'd1);
    chk("reboot_frame", 32'(q[0]), 32'h85);

    // Heartbeat instance: projectile held high across reset
    rst = 1'b1; hb_proj = 1'b1;
    tick(3);
    hb_q.delete(); hb_t.delete();
    rst = 1'b0;
    tick(200);
    chk("hb_count_min", 32'(hb_q.size() >= 4), 32'd1);
    chk("hb_boot", 32'(hb_q[0]), 32'h85);
    chk("hb_proj", 32'(hb_q[1]), 32'h15);
    chk("hb_beat1", 32'(hb_q[2]), 32'h15);
    chk("hb_beat2", 32'(hb_q[3]), 32'h15);
    chk("hb_period1", 32'(hb_t[2] - hb_t[1]), 32'd52);
    chk("hb_period2", 32'(hb_t[3] - hb_t[2]), 32'd52);
    chk("hb_lane", 32'(hb_lane), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
